keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display scanner.
- Drives a 4x4 matrix keypad one column at a time (active-low), samples the row lines and debounces. Each accepted key press is reported as a 4-bit code with a one-cycle valid pulse.
- Keeps an 8-digit BCD entry buffer that feeds the display scanner's 32-bit data input directly. Nibble 0xF displays blank.

---
 rtl/keypad_scan_pkg.sv | 59 +++++
 rtl/keypad_scan_tick.sv | 28 ++
 rtl/keypad_scan.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared constants, state encoding and scan helpers for the keypad scanner.
// Pure declarations; no timing or flow control of its own.
package keypad_scan_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] BLANK_NIB = 4'hF;
    localparam logic [3:0] COL_INIT  = 4'b1110;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAND    = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_REL     = 2'd3;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_class_e;

    typedef struct packed {
        scan_class_e cls;
        logic [3:0]  key;
    } scan_result_t;

    function automatic scan_result_t classify(input logic [15:0] map);
        scan_result_t res;
        logic [4:0]   n;
        res.cls = SCAN_NONE;
        res.key = 4'd0;
        n       = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) begin
                n       = n + 5'd1;
                res.key = 4'(i);
            end
        end
        if (n == 5'd1) begin
            res.cls = SCAN_SINGLE;
        end else if (n > 5'd1) begin
            res.cls = SCAN_MULTI;
        end
        return res;
    endfunction

    function automatic logic [31:0] next_digits(input logic [31:0] d, input logic [3:0] code);
        logic [31:0] nd;
        nd = d;
        if (code <= 4'd9) begin
            nd = {d[27:0], code};
        end else if (code == KEY_BKSP) begin
            nd = {BLANK_NIB, d[31:4]};
        end else if (code == KEY_CLR) begin
            nd = 32'hFFFF_FFFF;
        end
        return nd;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, on the cycle count==SCAN_DIV-1.
// No backpressure; the strobe is combinational from the counter.
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce and an 8-digit BCD entry buffer for the display scanner.
// Accept lands one clk after the last debouncing scan; no backpressure, key_valid is a bare pulse.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] digits
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS);

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col;
    logic [15:0]   r_map;
    logic [1:0]    r_state;
    logic [3:0]    r_cand;
    logic [DW-1:0] r_cnt;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_down;
    logic [31:0]   r_digits;

    logic          w_tick;
    logic          w_scan_done;
    logic [15:0]   w_col_hits;
    logic [15:0]   w_map_acc;
    scan_result_t  w_scan;
    logic          w_single;
    logic          w_empty;
    logic [DW-1:0] w_cnt_plus;
    logic [1:0]    w_state_nxt;
    logic [3:0]    w_cand_nxt;
    logic [DW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_release;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // Column 3's sample is merged in combinationally so the completing tick sees the whole scan.
    always_comb begin
        w_col_hits = '0;
        for (int r = 0; r < 4; r++) begin
            w_col_hits[{2'(r), r_col_idx}] = ~r_row_sync[r];
        end
    end

    assign w_map_acc   = r_map | w_col_hits;
    assign w_scan_done = w_tick && (r_col_idx == 2'd3);
    assign w_scan      = classify(w_map_acc);
    assign w_single    = (w_scan.cls == SCAN_SINGLE);
    assign w_empty     = (w_scan.cls == SCAN_NONE);
    assign w_cnt_plus  = r_cnt + DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_idx <= 2'd0;
            r_col     <= COL_INIT;
            r_map     <= '0;
        end else if (w_tick) begin
            r_col_idx <= r_col_idx + 2'd1;
            r_col     <= {r_col[2:0], r_col[3]};
            r_map     <= (r_col_idx == 2'd3) ? 16'd0 : w_map_acc;
        end
    end

    // Ghosted (multi-key) scans only count as "nothing" while acquiring a key; once a key
    // is held, any activity keeps it held so a second key cannot fake a release.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_single) begin
                    w_cand_nxt = w_scan.key;
                    if (DEBOUNCE_SCANS == 1) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = ST_CAND;
                        w_cnt_nxt   = DW'(1);
                    end
                end
            end
            ST_CAND: begin
                if (w_single && (w_scan.key == r_cand)) begin
                    if (w_cnt_plus == DEB_LAST) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_plus;
                    end
                end else if (w_single) begin
                    w_cand_nxt = w_scan.key;
                    w_cnt_nxt  = DW'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESSED: begin
                if (w_empty) begin
                    if (DEBOUNCE_SCANS == 1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_release   = 1'b1;
                    end else begin
                        w_state_nxt = ST_REL;
                        w_cnt_nxt   = DW'(1);
                    end
                end
            end
            default: begin
                if (!w_empty) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_plus == DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_plus;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_digits    <= 32'hFFFF_FFFF;
        end else begin
            r_key_valid <= w_scan_done && w_accept;
            if (w_scan_done) begin
                r_state <= w_state_nxt;
                r_cand  <= w_cand_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_accept) begin
                    r_key_code <= w_cand_nxt;
                    r_key_down <= 1'b1;
                    r_digits   <= next_digits(r_digits, w_cand_nxt);
                end else if (w_release) begin
                    r_key_down <= 1'b0;
                end
            end
        end
    end

    assign col_out   = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;
    assign digits    = r_digits;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives rows from col_out, expected
// accept events are queued at stimulus time and popped by a monitor on each key_valid.
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [31:0] digits;

    logic [15:0] keys;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] digits;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] kbit(input logic [3:0] code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: key_code %h digits %h, no pulse expected", key_code, digits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                chk("pulse_digits", digits, e.digits);
                chk("pulse_down", {31'd0, key_down}, 32'd1);
            end
        end
    end

    task automatic tap(input string name, input logic [15:0] k, input int scans,
                       input bit exp_pulse, input logic [3:0] code, input logic [31:0] d);
        if (exp_pulse) exp_q.push_back({code, d});
        keys = k;
        repeat (scans * 16) @(negedge clk);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_down_held"}, {31'd0, key_down}, {31'd0, exp_pulse});
        keys = '0;
        repeat (16) @(negedge clk);
        chk({name, "_down_rel1"}, {31'd0, key_down}, {31'd0, exp_pulse});
        repeat (48) @(negedge clk);
        chk({name, "_down_rel"}, {31'd0, key_down}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_col"}, {28'd0, col_out}, 32'h0000_000E);
        chk({name, "_code"}, {28'd0, key_code}, 32'd0);
        chk({name, "_valid"}, {31'd0, key_valid}, 32'd0);
        chk({name, "_down"}, {31'd0, key_down}, 32'd0);
        chk({name, "_digits"}, digits, 32'hFFFF_FFFF);
    endtask

    task automatic release_reset_and_check(input string name);
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_col_hold"}, {28'd0, col_out}, 32'h0000_000E);
        @(negedge clk);
        chk({name, "_col_step"}, {28'd0, col_out}, 32'h0000_000D);
        repeat (64) @(negedge clk);
        chk({name, "_quiet"}, {31'd0, key_down}, 32'd0);
    endtask

    task automatic wait_scan_start();
        int guard;
        guard = 0;
        while (col_out != 4'b0111 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        while (col_out != 4'b1110 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        chk("scan_align", {28'd0, col_out}, 32'h0000_000E);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] entry [1:9];
        entry[1] = 32'hFFFF_FFF1; entry[2] = 32'hFFFF_FF12; entry[3] = 32'hFFFF_F123;
        entry[4] = 32'hFFFF_1234; entry[5] = 32'hFFF1_2345; entry[6] = 32'hFF12_3456;
        entry[7] = 32'hF123_4567; entry[8] = 32'h1234_5678; entry[9] = 32'h2345_6789;
        n_vec = 0;
        n_err = 0;
        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        tap("key6", kbit(4'd6), 10, 1'b1, 4'd6, 32'hFFFF_FFF6);

        for (int i = 0; i < 5; i++) begin
            keys = kbit(4'd5);
            repeat (16) @(negedge clk);
            keys = '0;
            repeat (16) @(negedge clk);
        end
        repeat (32) @(negedge clk);
        chk("bounce_digits", digits, 32'hFFFF_FFF6);
        chk("bounce_down", {31'd0, key_down}, 32'd0);

        tap("clr1", kbit(4'hB), 4, 1'b1, 4'hB, 32'hFFFF_FFFF);
        tap("key3", kbit(4'd3), 4, 1'b1, 4'd3, 32'hFFFF_FFF3);
        tap("key7", kbit(4'd7), 4, 1'b1, 4'd7, 32'hFFFF_FF37);
        tap("bksp", kbit(4'hA), 4, 1'b1, 4'hA, 32'hFFFF_FFF3);

        tap("ghost", kbit(4'd6) | kbit(4'd9), 4, 1'b0, 4'd0, 32'd0);
        chk("ghost_digits", digits, 32'hFFFF_FFF3);

        exp_q.push_back({4'd6, 32'hFFFF_FF36});
        keys = kbit(4'd6);
        repeat (64) @(negedge clk);
        keys = kbit(4'd6) | kbit(4'd9);
        repeat (64) @(negedge clk);
        chk("second_key_pending", 32'(exp_q.size()), 32'd0);
        chk("second_key_down", {31'd0, key_down}, 32'd1);
        chk("second_key_code", {28'd0, key_code}, 32'd6);
        keys = '0;
        repeat (64) @(negedge clk);
        chk("second_key_rel", {31'd0, key_down}, 32'd0);

        tap("clr2", kbit(4'hB), 4, 1'b1, 4'hB, 32'hFFFF_FFFF);
        tap("bksp_blank", kbit(4'hA), 4, 1'b1, 4'hA, 32'hFFFF_FFFF);
        for (int i = 1; i <= 9; i++) begin
            tap("digit", kbit(4'(i)), 4, 1'b1, 4'(i), entry[i]);
        end
        chk("overflow_digits", digits, 32'h2345_6789);
        tap("keyD", kbit(4'hD), 4, 1'b1, 4'hD, 32'h2345_6789);
        tap("clr3", kbit(4'hB), 4, 1'b1, 4'hB, 32'hFFFF_FFFF);

        wait_scan_start();
        keys = kbit(4'd7);
        repeat (24) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_cand");
        release_reset_and_check("rst_cand");

        exp_q.push_back({4'd7, 32'hFFFF_FFF7});
        keys = kbit(4'd7);
        repeat (80) @(negedge clk);
        chk("rst_pressed_pending", 32'(exp_q.size()), 32'd0);
        chk("rst_pressed_down", {31'd0, key_down}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_pressed");
        release_reset_and_check("rst_pressed");

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
